uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers, such as a debug console, status reporter and sensor streamer. It accepts one byte per grant and drives the transmitter's send/data/ready handshake. It holds data stable until the transmitter acknowledges, then waits for the frame to finish before serving the next requester. A watchdog aborts an issue that is never acknowledged.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, byte width, matching the transmitter data port.
ACK_TIMEOUT, 16, max clk cycles in ISSUE waiting for tx_ready to fall before abort.
IDX_W, 2, width of grant_id; equals clog2(NUM_REQ).

Ports:
clk  in  1  system clock; all state changes on posedge.
rst  in  1  synchronous reset, active-low; sampled on posedge clk.
req  in  NUM_REQ  level request per requester; held until granted.
req_data  in  NUM_REQ*DATA_W  byte per requester; requester i occupies bits [i*DATA_W +: DATA_W].
grant  out  NUM_REQ  one-hot, 1-cycle pulse: requester's byte captured; requester may change data/drop req next cycle.
grant_id  out  IDX_W  index of the requester currently being served; valid while busy.
tx_send  out  1  to transmitter send.
tx_data  out  DATA_W  to transmitter data.
tx_ready  in  1  from transmitter ready.
busy  out  1  high whenever state != IDLE.
done  out  1  1-cycle pulse when a frame completes (tx_ready returns high).
err  out  1  1-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; tx_send=0; tx_data=0; grant=0; grant_id=0; busy=0; done=0; err=0; last pointer=NUM_REQ-1, so requester 0 wins first; watchdog=0.
- Reset overrides everything, including mid-ISSUE/WAIT. tx_send drops the cycle after reset is sampled. Any in-flight frame on the line is the transmitter's concern.
- States: IDLE, ISSUE, WAIT (2-bit encoding).
- IDLE: if tx_ready==1 and |req:
  - Winner = first set req scanning from last+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: tx_data<=req_data[winner], tx_send<=1, grant[winner]<=1 (single cycle), grant_id<=winner, last<=winner, watchdog<=0, state<=ISSUE.
  - If tx_ready==0 in IDLE, no grant is issued; the arbiter stays in IDLE.
- ISSUE: tx_send and tx_data held constant.
  - If tx_ready==0: tx_send<=0, state<=WAIT.
  - Else if watchdog==ACK_TIMEOUT-1: tx_send<=0, err<=1 for 1 cycle, state<=IDLE. The byte is dropped; last stays on the winner.
  - Else watchdog increments.
- WAIT: tx_send=0. When tx_ready==1: done<=1 for 1 cycle, state<=IDLE. There is no timeout in WAIT, because frame length is set by the transmitter baud timer.
- Grant-to-IDLE: minimum one IDLE cycle between frames. A new grant can occur on the cycle after done.
- Simultaneous requests: strict round-robin. A requester that was just served has lowest priority next round. A single persistent requester is served back-to-back.
- A requester that drops req before grant simply loses its turn; there is no penalty.
- req_data is sampled only at the grant edge. Changes at other times have no effect.
- The transmitter samples send on the opposite clock edge, so tx_send/tx_data must be glitch-free registered outputs.

Decomposition:
- Shared package/defines file: state encodings (ARB_IDLE, ARB_ISSUE, ARB_WAIT) and default ACK_TIMEOUT.
- One sub-module is natural: rr_priority_pick, combinational. Inputs req and last; outputs winner index and a valid flag. It is reusable for other shared peripherals.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> grant=0, tx_send=0, busy=0. Release, tx_ready=1 -> grant=4'b0001, tx_data=req_data[0].
- Single frame with model transmitter: req[2]=1, data 8'hA5 -> grant=4'b0100 pulse, tx_send=1 until tx_ready falls, then tx_data=8'hA5 on the wire, done pulse once, busy low after.
- Fairness: req=4'b1011 held constant, each requester sending a distinct byte -> grant order 0,1,3,0,1,3 with exactly one done per grant.
- Watchdog: tx_ready stuck at 1, req[1]=1 -> tx_send high for exactly 16 cycles, err pulses once, return to IDLE, next grant goes to requester 1 again only if it is the sole requester.
- Mid-operation reset: assert rst=0 during WAIT -> next cycle state IDLE, busy=0, tx_send=0, no done pulse. Pointer restarts at requester 0.
- Not-ready gating: tx_ready=0 in IDLE with req=4'b0001 -> no grant until tx_ready=1, then grant on the following posedge.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encodings, default watchdog limit and round-robin index helper
// for the UART transmit arbiter; purely declarative, no timing or flow control.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int ACK_TIMEOUT_DEF = 16;

  function automatic int rr_idx(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin pick: first set request after last, wrapping.
// Zero latency; no backpressure, vld_o low when nothing is requesting.
module rr_priority_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               vld_o
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the nearest candidate after last overwrites the rest.
  always_comb begin
    winner_o = '0;
    vld_o    = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'(rr_idx(int'(last_i), k, NUM_REQ));
      if (req_i[idx]) begin
        winner_o = idx;
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; grant one cycle after a request in IDLE,
// send held until tx_ready falls, next grant only after the frame ends or the watchdog fires.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int IDX_W       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    grant_id_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [WD_W-1:0]     wd_q;
  logic                tx_send_q;
  logic                done_q;
  logic                err_q;
  logic [IDX_W-1:0]    winner;
  logic                win_vld;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .vld_o    (win_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      wd_q       <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (tx_ready && win_vld) begin
            tx_data_q  <= req_data[winner*DATA_W +: DATA_W];
            tx_send_q  <= 1'b1;
            grant_q    <= NUM_REQ'(1) << winner;
            grant_id_q <= winner;
            last_q     <= winner;
            wd_q       <= '0;
            state_q    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!tx_ready) begin
            tx_send_q <= 1'b0;
            state_q   <= ARB_WAIT;
          end else if (wd_q == WD_LAST) begin
            // Never acknowledged: drop the byte, pointer stays on this winner.
            tx_send_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ARB_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ARB_WAIT: begin
          if (tx_ready) begin
            done_q  <= 1'b1;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != ARB_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level arbitration model, model transmitter,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            tx_ready;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            tx_send;
  logic [DW-1:0]   tx_data;
  logic            busy, done, err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(TO), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .grant_id(grant_id), .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int xm_mode   = 0;   // 0 = normal transmitter, 1 = ready stuck high, 2 = ready held low
  logic [DW-1:0] last_wire = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte is "in service" from grant until acknowledged-and-finished or abandoned.
  bit            m_valid = 0;
  bit            serving, acked;
  int            age, last, pick;
  logic [N-1:0]  e_grant;
  logic          e_send, e_done, e_err;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_id;

  always @(posedge clk) begin
    e_grant = '0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (!rst) begin
      serving = 0; acked = 0; age = 0; last = N - 1;
      e_send = 1'b0; e_data = '0; e_id = '0;
      m_valid = 1;
    end else if (!serving) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req[(last + k) % N]) pick = (last + k) % N;
      if (tx_ready && pick >= 0) begin
        serving = 1; acked = 0; age = 0; last = pick;
        e_grant[pick] = 1'b1;
        e_id   = IW'(pick);
        e_data = req_data[pick*DW +: DW];
        e_send = 1'b1;
      end
    end else if (!acked) begin
      if (!tx_ready) begin
        acked = 1; e_send = 1'b0;
      end else if (age == TO - 1) begin
        serving = 0; e_send = 1'b0; e_err = 1'b1;
      end else begin
        age++;
      end
    end else if (tx_ready) begin
      serving = 0; acked = 0; e_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant",   grant,   e_grant);
      chk("tx_send", tx_send, e_send);
      chk("tx_data", tx_data, e_data);
      chk("busy",    busy,    serving);
      chk("done",    done,    e_done);
      chk("err",     err,     e_err);
      if (serving) chk("grant_id", grant_id, e_id);
      if (done === 1'b1) done_seen++;
      if (err === 1'b1)  err_seen++;
    end
  end

  // Model transmitter: acknowledges a send after 0..2 cycles, frame lasts 1..5 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (xm_mode == 1) tx_ready = 1'b1;
      else if (xm_mode == 2) tx_ready = 1'b0;
      else if (tx_send === 1'b1 && tx_ready) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        last_wire = tx_data;
        tx_ready  = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        tx_ready  = 1'b1;
      end else tx_ready = 1'b1;
    end
  end

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 200 && g == '0; i++) begin
      @(negedge clk);
      g = grant;
    end
    if (g == '0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_grant: no grant within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy !== 1'b0 && i < 300);
    if (busy !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: still busy after 300 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    int d0, e0, hi;
    int order[$];
    int exp_ord[6] = '{0, 1, 3, 0, 1, 3};

    rst = 1'b0; req = 4'b1111; req_data = {8'h44, 8'h33, 8'h22, 8'h11}; xm_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_send", tx_send, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);
    chk("first_data", tx_data, 8'h11);
    req = '0;
    wait_idle();

    // Single frame from requester 2.
    req_data = '0; req_data[2*DW +: DW] = 8'hA5; req = 4'b0100;
    d0 = done_seen;
    wait_grant(g);
    chk("single_grant", g, 4'b0100);
    req = '0;
    wait_idle();
    chk("single_wire", last_wire, 8'hA5);
    chk("single_done_cnt", done_seen - d0, 1);
    chk("single_busy", busy, 1'b0);

    // Fairness from a fresh pointer.
    rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; req = 4'b1011;
    d0 = done_seen;
    for (int i = 0; i < 600 && order.size() < 6; i++) begin
      @(negedge clk);
      if (grant != '0) order.push_back($clog2(grant));
    end
    req = '0;
    wait_idle();
    chk("fair_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("fair_order", order[i], exp_ord[i]);
    chk("fair_done_cnt", done_seen - d0, 6);

    // Watchdog with ready stuck high.
    xm_mode = 1; @(negedge clk);
    e0 = err_seen;
    req_data[1*DW +: DW] = 8'h5C; req = 4'b0010;
    wait_grant(g);
    chk("wd_grant", g, 4'b0010);
    req = '0;
    hi = 0;
    while (tx_send === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("wd_send_cycles", hi, TO);
    chk("wd_err_pulse", err, 1'b1);
    repeat (3) @(negedge clk);
    chk("wd_err_cnt", err_seen - e0, 1);
    chk("wd_busy", busy, 1'b0);
    req = 4'b1010;
    wait_grant(g);
    chk("wd_next_other", g, 4'b1000);
    req = '0;
    wait_idle();
    req = 4'b0010;
    wait_grant(g);
    chk("wd_sole_again", g, 4'b0010);
    req = '0;
    wait_idle();

    // Reset during WAIT.
    xm_mode = 0; @(negedge clk);
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    hi = 0;
    while (!(busy === 1'b1 && tx_send === 1'b0) && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    chk("mid_reached_wait", hi < 50, 1'b1);
    d0 = done_seen;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_send", tx_send, 1'b0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_no_done", done_seen - d0, 0);
    req = 4'b1111;
    wait_grant(g);
    chk("mid_ptr_restart", g, 4'b0001);
    req = '0;
    wait_idle();

    // Not-ready gating.
    xm_mode = 2; repeat (2) @(negedge clk);
    req = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      chk("gate_no_grant", grant, 4'b0000);
    end
    xm_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (tx_ready === 1'b1) break;
    end
    @(negedge clk);
    chk("gate_grant", grant, 4'b0001);
    req = '0;
    wait_idle();

    // Randomized soak against the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (c % 25 == 0) begin
        hi = $urandom_range(0, 99);
        xm_mode = (hi < 70) ? 0 : (hi < 85) ? 1 : 2;
      end
      req      = N'($urandom);
      req_data = {$urandom};
      rst      = ($urandom_range(0, 149) != 0);
    end
    rst = 1'b1; req = '0; xm_mode = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
